ps2_device_model: RTL and testbench

- Parametrised, synthesizable PS/2 device-side transmitter used in place of a physical keyboard on `PS2_CLK`/`PS2_DATA` for `system` simulation and FPGA self-test.
- Buffers scancode bytes in a FIFO and serialises each one as an 11-bit PS/2 frame, generating its own PS/2 clock from the system clock.
- Supports host inhibit, where the host holds the clock low: a frame interrupted by inhibit is aborted and re-sent once inhibit is released.

---
 rtl/ps2_device_model_if.sv | 10 +
 rtl/ps2_device_model.sv | 192 +++++++++++++++++++
 tb/tb_ps2_device_model.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_device_model_if.sv
// Byte-stream handshake carrying scancodes into the PS/2 device model.
// The producer drives data/valid; the model returns ready while its FIFO has room.
interface ps2_device_model_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ps2_device_model.sv
// PS/2 device-side transmitter: FIFO-buffered scancodes sent as 11-bit frames with a self-generated clock.
// Optional macro PS2_MODEL_PARITY_ERR_EN adds err_inject to force even parity on a chosen frame.
module ps2_device_model #(
    parameter int DEPTH    = 8,
    parameter int CLK_HALF = 2500,
    parameter int GAP      = 5000
) (
    input  logic                     clk,
    input  logic                     resetn,
    ps2_device_model_if.slave        in_if,
    input  logic                     inhibit,
`ifdef PS2_MODEL_PARITY_ERR_EN
    input  logic                     err_inject,
`endif
    output logic                     ps2_clk,
    output logic                     ps2_data,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              frames_sent
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int PH_W  = $clog2(2 * CLK_HALF);
    localparam int GAP_W = $clog2(GAP + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [1:0]       state_q, state_d;
    logic [10:0]      frame_q, frame_d;
    logic [3:0]       bit_q, bit_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ps2clk_q, ps2clk_d;
    logic             ps2data_q, ps2data_d;
    logic [15:0]      frames_q, frames_d;
    logic             push;
    logic             pop;
    logic [7:0]       head;
    logic             parity;

    assign in_if.in_ready = (level_q != LVL_W'(DEPTH));
    assign push           = in_if.in_valid && in_if.in_ready;
    assign head           = mem[rptr_q];

    assign ps2_clk     = ps2clk_q;
    assign ps2_data    = ps2data_q;
    assign busy        = (state_q != ST_IDLE);
    assign level       = level_q;
    assign frames_sent = frames_q;

`ifdef PS2_MODEL_PARITY_ERR_EN
    // A retransmission after an abort always goes out with correct parity.
    logic retry_q, retry_d;
    assign parity = (~^head) ^ (err_inject && !retry_q);
`else
    assign parity = ~^head;
`endif

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        gap_d     = gap_q;
        ps2clk_d  = ps2clk_q;
        ps2data_d = ps2data_q;
        frames_d  = frames_q;
        pop       = 1'b0;
`ifdef PS2_MODEL_PARITY_ERR_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (level_q != '0 && !inhibit) begin
                    frame_d   = {1'b1, parity, head, 1'b0};
                    bit_d     = 4'd0;
                    phase_d   = '0;
                    ps2clk_d  = 1'b1;
                    ps2data_d = 1'b0;
                    state_d   = ST_SEND;
`ifdef PS2_MODEL_PARITY_ERR_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            ST_SEND: begin
                if (inhibit && bit_q < 4'd10) begin
                    ps2clk_d  = 1'b1;
                    ps2data_d = 1'b1;
                    state_d   = ST_ABORT;
`ifdef PS2_MODEL_PARITY_ERR_EN
                    retry_d   = 1'b1;
`endif
                end else if (phase_q == PH_W'(2 * CLK_HALF - 1)) begin
                    phase_d  = '0;
                    ps2clk_d = 1'b1;
                    if (bit_q == 4'd10) begin
                        pop       = 1'b1;
                        frames_d  = frames_q + 16'd1;
                        ps2data_d = 1'b1;
                        gap_d     = '0;
                        state_d   = ST_GAP;
                    end else begin
                        // frame_q[0] is always the bit currently on the line.
                        bit_d     = bit_q + 4'd1;
                        frame_d   = {1'b1, frame_q[10:1]};
                        ps2data_d = frame_q[1];
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                    if (phase_q == PH_W'(CLK_HALF - 1)) begin
                        ps2clk_d = 1'b0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_ABORT: begin
                if (!inhibit) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in_if.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            frame_q   <= '1;
            bit_q     <= 4'd0;
            phase_q   <= '0;
            gap_q     <= '0;
            ps2clk_q  <= 1'b1;
            ps2data_q <= 1'b1;
            frames_q  <= 16'd0;
`ifdef PS2_MODEL_PARITY_ERR_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            frame_q   <= frame_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            gap_q     <= gap_d;
            ps2clk_q  <= ps2clk_d;
            ps2data_q <= ps2data_d;
            frames_q  <= frames_d;
`ifdef PS2_MODEL_PARITY_ERR_EN
            retry_q   <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_device_model.sv
// Bench for ps2_device_model: directed pushes queue hand-computed frames; a line monitor decodes PS/2 frames and checks them.
// Build with PS2_MODEL_PARITY_ERR_EN defined to exercise the parity-error injection path as well.
module tb_ps2_device_model;

    localparam int DEPTH    = 4;
    localparam int CLK_HALF = 4;
    localparam int GAP      = 8;

    logic                    clk;
    logic                    resetn;
    logic                    inhibit;
    logic                    ps2_clk;
    logic                    ps2_data;
    logic                    busy;
    logic [$clog2(DEPTH):0]  level;
    logic [15:0]             frames_sent;
`ifdef PS2_MODEL_PARITY_ERR_EN
    logic                    errInj;
`endif

    int          testsRun;
    int          testsFailed;
    logic [10:0] expQ [$];

    ps2_device_model_if inIf ();

    ps2_device_model #(.DEPTH(DEPTH), .CLK_HALF(CLK_HALF), .GAP(GAP)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_if       (inIf),
        .inhibit     (inhibit),
`ifdef PS2_MODEL_PARITY_ERR_EN
        .err_inject  (errInj),
`endif
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .busy        (busy),
        .level       (level),
        .frames_sent (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Pushes one byte; expFrame is the hand-computed frame the monitor should later see.
    task automatic applyStimulus(input logic [7:0] d, input logic [10:0] expFrame,
                                 input logic expAccept, input logic track);
        @(negedge clk);
        inIf.in_data  = d;
        inIf.in_valid = 1'b1;
        checkOutput("in_ready", 32'(inIf.in_ready), 32'(expAccept));
        @(posedge clk);
        #1;
        inIf.in_valid = 1'b0;
        if (expAccept && track) expQ.push_back(expFrame);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (int'(frames_sent) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frames_sent", 32'(frames_sent), 32'(target));
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busy after gap", 32'(busy), 32'd0);
    endtask

    // Line monitor: samples on system-clock falling edges, decodes LSB-first frames at ps2_clk falls.
    initial begin
        logic        prevClk;
        int          bitCnt;
        int          highCnt;
        int          lowCnt;
        logic [10:0] shift;
        logic [10:0] expF;
        prevClk = 1'b1;
        bitCnt  = 0;
        highCnt = 0;
        lowCnt  = 0;
        shift   = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                bitCnt  = 0;
                highCnt = 0;
                lowCnt  = 0;
                prevClk = 1'b1;
            end else begin
                if (prevClk && !ps2_clk) begin
                    if (bitCnt > 0) begin
                        checkOutput("bit high width", 32'(highCnt), 32'(CLK_HALF));
                        checkOutput("bit low width", 32'(lowCnt), 32'(CLK_HALF));
                    end
                    shift   = {ps2_data, shift[10:1]};
                    bitCnt++;
                    lowCnt  = 1;
                    highCnt = 0;
                    if (bitCnt == 11) begin
                        if (expQ.size() == 0) begin
                            testsRun++;
                            testsFailed++;
                            $display("[TB] FAIL frame: got 0x%0h, required no frame", shift);
                        end else begin
                            expF = expQ.pop_front();
                            checkOutput("frame", 32'(shift), 32'(expF));
                        end
                        bitCnt = 0;
                    end
                end else if (!ps2_clk) begin
                    lowCnt++;
                end else begin
                    highCnt++;
                    if (bitCnt != 0 && highCnt > 2 * CLK_HALF) bitCnt = 0;
                end
                prevClk = ps2_clk;
            end
        end
    end

    initial begin
        testsRun      = 0;
        testsFailed   = 0;
        resetn        = 1'b0;
        inhibit       = 1'b0;
        inIf.in_valid = 1'b0;
        inIf.in_data  = 8'h00;
`ifdef PS2_MODEL_PARITY_ERR_EN
        errInj        = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ps2_clk", 32'(ps2_clk), 32'd1);
        checkOutput("reset ps2_data", 32'(ps2_data), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset level", 32'(level), 32'd0);
        checkOutput("reset in_ready", 32'(inIf.in_ready), 32'd1);
        checkOutput("reset frames_sent", 32'(frames_sent), 32'd0);
        resetn = 1'b1;

        $display("[TB] single frame 0x1C with cycle timing");
        applyStimulus(8'h1C, {1'b1, 1'b0, 8'h1C, 1'b0}, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("t1 level after push", 32'(level), 32'd1);
        checkOutput("t1 busy before start", 32'(busy), 32'd0);
        checkOutput("t1 data before start", 32'(ps2_data), 32'd1);
        @(negedge clk);
        checkOutput("t1 start bit", 32'(ps2_data), 32'd0);
        checkOutput("t1 busy in frame", 32'(busy), 32'd1);
        checkOutput("t1 clk high phase", 32'(ps2_clk), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("t1 clk low phase", 32'(ps2_clk), 32'd0);
        repeat (84) @(negedge clk);
        checkOutput("t1 frames_sent", 32'(frames_sent), 32'd1);
        checkOutput("t1 level after pop", 32'(level), 32'd0);
        checkOutput("t1 busy in gap", 32'(busy), 32'd1);
        checkOutput("t1 clk in gap", 32'(ps2_clk), 32'd1);
        checkOutput("t1 data in gap", 32'(ps2_data), 32'd1);
        repeat (7) @(negedge clk);
        checkOutput("t1 busy end of gap", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("t1 busy after gap", 32'(busy), 32'd0);

        $display("[TB] fill FIFO under inhibit");
        inhibit = 1'b1;
        applyStimulus(8'h01, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b1, 1'b1);
        applyStimulus(8'h02, {1'b1, 1'b0, 8'h02, 1'b0}, 1'b1, 1'b1);
        applyStimulus(8'h03, {1'b1, 1'b1, 8'h03, 1'b0}, 1'b1, 1'b1);
        applyStimulus(8'h04, {1'b1, 1'b0, 8'h04, 1'b0}, 1'b1, 1'b1);
        applyStimulus(8'h05, {1'b1, 1'b0, 8'h05, 1'b0}, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t2 level full", 32'(level), 32'd4);
        checkOutput("t2 clk inhibited", 32'(ps2_clk), 32'd1);
        checkOutput("t2 data inhibited", 32'(ps2_data), 32'd1);
        checkOutput("t2 busy inhibited", 32'(busy), 32'd0);
        inhibit = 1'b0;
        waitFrames(5, 1000);
        waitIdle(100);
        checkOutput("t2 level drained", 32'(level), 32'd0);

        $display("[TB] abort during bit 5 and retransmit");
        applyStimulus(8'hF0, {1'b1, 1'b1, 8'hF0, 1'b0}, 1'b1, 1'b1);
        repeat (43) @(negedge clk);
        inhibit = 1'b1;
        @(negedge clk);
        checkOutput("t3 clk aborted", 32'(ps2_clk), 32'd1);
        checkOutput("t3 data aborted", 32'(ps2_data), 32'd1);
        checkOutput("t3 level kept", 32'(level), 32'd1);
        checkOutput("t3 busy aborted", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("t3 frames not counted", 32'(frames_sent), 32'd5);
        checkOutput("t3 busy held", 32'(busy), 32'd1);
        inhibit = 1'b0;
        waitFrames(6, 400);
        waitIdle(100);

        $display("[TB] inhibit during stop bit");
        applyStimulus(8'h5A, {1'b1, 1'b1, 8'h5A, 1'b0}, 1'b1, 1'b1);
        repeat (82) @(negedge clk);
        inhibit = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("t4 frames_sent", 32'(frames_sent), 32'd7);
        inhibit = 1'b0;
        waitIdle(100);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hAA, {1'b1, 1'b1, 8'hAA, 1'b0}, 1'b1, 1'b0);
        applyStimulus(8'hBB, {1'b1, 1'b1, 8'hBB, 1'b0}, 1'b1, 1'b0);
        applyStimulus(8'hCC, {1'b1, 1'b1, 8'hCC, 1'b0}, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("t5 level before reset", 32'(level), 32'd3);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5 clk", 32'(ps2_clk), 32'd1);
        checkOutput("t5 data", 32'(ps2_data), 32'd1);
        checkOutput("t5 level", 32'(level), 32'd0);
        checkOutput("t5 frames_sent", 32'(frames_sent), 32'd0);
        checkOutput("t5 in_ready", 32'(inIf.in_ready), 32'd1);
        checkOutput("t5 busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (120) @(negedge clk);
        checkOutput("t5 nothing sent", 32'(frames_sent), 32'd0);

`ifdef PS2_MODEL_PARITY_ERR_EN
        $display("[TB] parity error injection");
        errInj = 1'b1;
        applyStimulus(8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        errInj = 1'b0;
        applyStimulus(8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b1, 1'b1);
        waitFrames(2, 400);
        waitIdle(100);
`endif

        repeat (10) @(negedge clk);
        checkOutput("all frames seen", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
